// File: rtl/fetch_prefetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_pkg
//   Shared definitions for the prefetching fetch stage: default index and
//   instruction widths, the fetch FSM state encoding, and the sign-extension
//   helper used by the PC-relative redirect adder.
// ---------------------------------------------------------------------------
package fetch_prefetch_queue_pkg;

  localparam int FETCH_IDX_W  = 32;
  localparam int FETCH_INSN_W = 16;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_KILL = 1'b1
  } fetch_state_e;

  // Sign-extends the low 'width' bits of 'value' to 64 bits.
  function automatic logic [63:0] sext(input logic [63:0] value, input int unsigned width);
    logic [63:0] keep;
    logic        sign;
    keep = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sign = ((value >> (width - 1)) & 64'd1) != 64'd0;
    return sign ? (value | ~keep) : (value & keep);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_if
//   Bundles the three buses of the fetch stage:
//     icache   : ic_not_enable (active-low read enable), ic_index, ic_data
//     decoder  : out_valid / out_ready handshake carrying out_insn, out_index
//     redirect : redirect_valid, redirect_rel, redirect_value
//   master = fetch stage, slave = surrounding icache/decoder/branch logic.
// ---------------------------------------------------------------------------
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int IDX_W  = FETCH_IDX_W,
  parameter int INSN_W = FETCH_INSN_W
);
  logic              ic_not_enable;
  logic [IDX_W-1:0]  ic_index;
  logic [INSN_W-1:0] ic_data;
  logic              out_valid;
  logic              out_ready;
  logic [INSN_W-1:0] out_insn;
  logic [IDX_W-1:0]  out_index;
  logic              redirect_valid;
  logic              redirect_rel;
  logic [IDX_W-1:0]  redirect_value;

  modport master (
    output ic_not_enable, ic_index, out_valid, out_insn, out_index,
    input  ic_data, out_ready, redirect_valid, redirect_rel, redirect_value
  );

  modport slave (
    input  ic_not_enable, ic_index, out_valid, out_insn, out_index,
    output ic_data, out_ready, redirect_valid, redirect_rel, redirect_value
  );
endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_fifo
//   DEPTH-entry FIFO of {index, instruction} records for the fetch stage.
//   Ports: clk, rst (async, active-high), push/push_data, pop, flush,
//          head_data (entry at read pointer), count (0..DEPTH), full, empty.
//   flush empties the queue and overrides push/pop in the same cycle.
// ---------------------------------------------------------------------------
module fetch_prefetch_queue_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 48,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//   Fetch stage: owns the halfword program index, issues reads to a 1-cycle
//   synchronous icache, queues returned instructions and hands them to decode
//   over a valid/ready handshake. Absolute or PC-relative redirects flush the
//   queue and drop the read whose data is returning.
//   Ports: clk, rst (async, active-high), bus (fetch_prefetch_queue_if.master)
//   Optional (macro FETCH_STATS_EN): stat_stall_cnt, stat_redir_cnt, both
//   saturating 32-bit counters.
// ---------------------------------------------------------------------------
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int               IDX_W       = FETCH_IDX_W,
  parameter int               INSN_W      = FETCH_INSN_W,
  parameter int               DEPTH       = 4,
  parameter logic [IDX_W-1:0] RESET_INDEX = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_queue_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_stall_cnt,
  output logic [31:0]           stat_redir_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = IDX_W + INSN_W;

  fetch_state_e             state_q;
  fetch_state_e             state_d;
  logic [IDX_W-1:0]         fetch_index;
  logic [IDX_W-1:0]         head_index;
  logic [IDX_W-1:0]         target_p0;
  logic signed [IDX_W-1:0]  rel_delta_p0;
  logic [OCC_W-1:0]         occupancy_p0;
  logic                     issue_p0;
  logic                     deq_p0;
  logic                     vld_p1;
  logic [IDX_W-1:0]         idx_p1;
  logic                     push_p1;
  logic [ENT_W-1:0]         head_ent;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic [INSN_W-1:0]        hold_insn;
  logic [IDX_W-1:0]         hold_index;

  // p0: issue decision and redirect target
  assign deq_p0       = !empty && bus.out_ready;
  // Credit counts the returning read so the queue never overflows.
  assign occupancy_p0 = OCC_W'(count) + OCC_W'(vld_p1) - OCC_W'(deq_p0);
  assign issue_p0     = !rst && !bus.redirect_valid && !(full && !deq_p0)
                        && (occupancy_p0 < OCC_W'(DEPTH));

  always_comb begin
    rel_delta_p0 = $signed(IDX_W'(sext(64'(bus.redirect_value), IDX_W)));
    target_p0    = bus.redirect_value;
    if (bus.redirect_rel) target_p0 = head_index + $unsigned(rel_delta_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_index <= RESET_INDEX;
      head_index  <= RESET_INDEX;
      vld_p1      <= 1'b0;
      state_q     <= FETCH_RUN;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue_p0;
      if (bus.redirect_valid) begin
        fetch_index <= target_p0;
        head_index  <= target_p0;
      end else begin
        if (issue_p0) fetch_index <= fetch_index + IDX_W'(1);
        if (deq_p0)   head_index  <= head_index + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) idx_p1 <= fetch_index;
  end

  // KILL marks the cycle after a redirect that dropped a returning read.
  always_comb begin
    state_d = FETCH_RUN;
    case (state_q)
      FETCH_RUN:  if (bus.redirect_valid && vld_p1) state_d = FETCH_KILL;
      FETCH_KILL: state_d = FETCH_RUN;
      default:    state_d = FETCH_RUN;
    endcase
  end

  // p1: icache data returns and is queued with its index
  assign push_p1 = vld_p1 && (state_q == FETCH_RUN) && !bus.redirect_valid;

  fetch_prefetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_p1),
    .push_data ({idx_p1, bus.ic_data}),
    .pop       (deq_p0),
    .flush     (bus.redirect_valid),
    .head_data (head_ent),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Last delivered instruction, shown on the outputs while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_insn  <= '0;
      hold_index <= RESET_INDEX;
    end else if (deq_p0) begin
      hold_insn  <= head_ent[INSN_W-1:0];
      hold_index <= head_ent[ENT_W-1:INSN_W];
    end
  end

  assign bus.ic_not_enable = !issue_p0;
  assign bus.ic_index      = fetch_index;
  assign bus.out_valid     = !empty;
  assign bus.out_insn      = empty ? hold_insn  : head_ent[INSN_W-1:0];
  assign bus.out_index     = empty ? hold_index : head_ent[ENT_W-1:INSN_W];

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_redir_cnt <= '0;
    end else begin
      if (empty)              stat_stall_cnt <= sat_inc(stat_stall_cnt);
      if (bus.redirect_valid) stat_redir_cnt <= sat_inc(stat_redir_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//   Directed bench for fetch_prefetch_queue (DEPTH=4, IDX_W=32, INSN_W=16).
//   A behavioural icache returns index[15:0] one cycle after each read.
//   Stats checks are compiled in when FETCH_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

  localparam int IDX_W  = 32;
  localparam int INSN_W = 16;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 34;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic        rrel;
    logic [31:0] rval;
    logic        ne;
    logic [31:0] idx;
    logic        ov;
    logic [31:0] oidx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.IDX_W(IDX_W), .INSN_W(INSN_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_redir_cnt;
`endif

  fetch_prefetch_queue #(
    .IDX_W       (IDX_W),
    .INSN_W      (INSN_W),
    .DEPTH       (DEPTH),
    .RESET_INDEX (32'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_redir_cnt (stat_redir_cnt)
`endif
  );

  // icache model: 1-cycle synchronous read, garbage when not enabled
  initial bus.ic_data = 16'hDEAD;
  always @(posedge clk) begin
    if (!bus.ic_not_enable) bus.ic_data <= bus.ic_index[15:0];
    else                    bus.ic_data <= 16'hDEAD;
  end

  function automatic vec_t mk(input logic rdy, input logic rv, input logic rrel,
                              input logic [31:0] rval, input logic ne,
                              input logic [31:0] idx, input logic ov,
                              input logic [31:0] oidx);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rrel = rrel; v.rval = rval;
    v.ne = ne; v.idx = idx; v.ov = ov; v.oidx = oidx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic rrel, input logic [31:0] rval);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_rel   = rrel;
    bus.redirect_value = rval;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ic_not_enable"}, 32'(bus.ic_not_enable), 32'd1);
    chk({tag, " ic_index"},      bus.ic_index,           32'd0);
    chk({tag, " out_valid"},     32'(bus.out_valid),     32'd0);
    chk({tag, " out_index"},     bus.out_index,          32'd0);
    chk({tag, " out_insn"},      32'(bus.out_insn),      32'd0);
`ifdef FETCH_STATS_EN
    chk({tag, " stat_stall_cnt"}, stat_stall_cnt, 32'd0);
    chk({tag, " stat_redir_cnt"}, stat_redir_cnt, 32'd0);
`endif
  endtask

  initial begin
    int issues;
    int got;
    logic [31:0] oidx_l;

    //             rdy rv rel value          ne idx           ov oidx
    vecs[0]  = mk(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,          0, 32'h1,        0, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,          0, 32'h2,        1, 32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h0,          0, 32'h3,        1, 32'h1);
    vecs[4]  = mk(1, 0, 0, 32'h0,          0, 32'h4,        1, 32'h2);
    vecs[5]  = mk(0, 0, 0, 32'h0,          0, 32'h5,        1, 32'h3);
    vecs[6]  = mk(0, 0, 0, 32'h0,          0, 32'h6,        1, 32'h3);
    vecs[7]  = mk(0, 0, 0, 32'h0,          1, 32'h7,        1, 32'h3);
    vecs[8]  = mk(0, 0, 0, 32'h0,          1, 32'h7,        1, 32'h3);
    vecs[9]  = mk(0, 0, 0, 32'h0,          1, 32'h7,        1, 32'h3);
    vecs[10] = mk(1, 0, 0, 32'h0,          0, 32'h7,        1, 32'h3);
    vecs[11] = mk(1, 0, 0, 32'h0,          0, 32'h8,        1, 32'h4);
    vecs[12] = mk(1, 0, 0, 32'h0,          0, 32'h9,        1, 32'h5);
    vecs[13] = mk(1, 1, 1, 32'hFFFF_FFFE,  1, 32'hA,        1, 32'h6);
    vecs[14] = mk(1, 0, 0, 32'h0,          0, 32'h4,        0, 32'h6);
    vecs[15] = mk(1, 0, 0, 32'h0,          0, 32'h5,        0, 32'h6);
    vecs[16] = mk(1, 0, 0, 32'h0,          0, 32'h6,        1, 32'h4);
    vecs[17] = mk(1, 0, 0, 32'h0,          0, 32'h7,        1, 32'h5);
    vecs[18] = mk(1, 1, 0, 32'h100,        1, 32'h8,        1, 32'h6);
    vecs[19] = mk(1, 0, 0, 32'h0,          0, 32'h100,      0, 32'h6);
    vecs[20] = mk(1, 0, 0, 32'h0,          0, 32'h101,      0, 32'h6);
    vecs[21] = mk(1, 0, 0, 32'h0,          0, 32'h102,      1, 32'h100);
    vecs[22] = mk(1, 1, 0, 32'h200,        1, 32'h103,      1, 32'h101);
    vecs[23] = mk(1, 1, 0, 32'h300,        1, 32'h200,      0, 32'h101);
    vecs[24] = mk(1, 0, 0, 32'h0,          0, 32'h300,      0, 32'h101);
    vecs[25] = mk(1, 0, 0, 32'h0,          0, 32'h301,      0, 32'h101);
    vecs[26] = mk(1, 0, 0, 32'h0,          0, 32'h302,      1, 32'h300);
    vecs[27] = mk(1, 1, 0, 32'hFFFF_FFFF,  1, 32'h303,      1, 32'h301);
    vecs[28] = mk(1, 0, 0, 32'h0,          0, 32'hFFFF_FFFF, 0, 32'h301);
    vecs[29] = mk(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h301);
    vecs[30] = mk(1, 1, 1, 32'h1,          1, 32'h1,        1, 32'hFFFF_FFFF);
    vecs[31] = mk(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'hFFFF_FFFF);
    vecs[32] = mk(1, 0, 0, 32'h0,          0, 32'h1,        0, 32'hFFFF_FFFF);
    vecs[33] = mk(1, 0, 0, 32'h0,          0, 32'h2,        1, 32'h0);

    // reset
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    // table: streaming, back-pressure, redirects, index wrap
    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) rst = 1'b0;
      drive(vecs[k].rdy, vecs[k].rv, vecs[k].rrel, vecs[k].rval);
      @(negedge clk);
      chk($sformatf("v%0d ic_not_enable", k), 32'(bus.ic_not_enable), 32'(vecs[k].ne));
      chk($sformatf("v%0d ic_index", k),      bus.ic_index,           vecs[k].idx);
      chk($sformatf("v%0d out_valid", k),     32'(bus.out_valid),     32'(vecs[k].ov));
      chk($sformatf("v%0d out_index", k),     bus.out_index,          vecs[k].oidx);
      oidx_l = vecs[k].oidx;
      chk($sformatf("v%0d out_insn", k),      32'(bus.out_insn),      {16'h0, oidx_l[15:0]});
    end

    // reset mid-operation, then fill with decoder stalled
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.ic_not_enable) issues++;
      @(posedge clk);
      #1;
    end
    chk("stall issue count", 32'(issues), 32'd4);
    @(negedge clk);
    chk("stall ic_not_enable", 32'(bus.ic_not_enable), 32'd1);
    chk("stall out_valid", 32'(bus.out_valid), 32'd1);

    // release decoder: queued 0..3 delivered in order
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk($sformatf("drain idx%0d", got), bus.out_index, 32'(got));
        chk($sformatf("drain insn%0d", got), 32'(bus.out_insn), 32'(got));
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("drain count", 32'(got), 32'd4);

`ifdef FETCH_STATS_EN
    // statistics: 3 redirects, 8 empty cycles before the sample point
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk_reset_state("statrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (c == 4 || c == 8 || c == 12) drive(1'b1, 1'b1, 1'b0, 32'(c * 16));
      else                             drive(1'b1, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("stat_redir_cnt", stat_redir_cnt, 32'd3);
    chk("stat_stall_cnt", stat_stall_cnt, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
